// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 round register block.
// Contents: register offsets, FINISH bit positions, FSM encoding and round functions.
package sha256_pkg;

  localparam logic [15:0] OFF_IA     = 16'h0000;
  localparam logic [15:0] OFF_OA     = 16'h0020;
  localparam logic [15:0] OFF_FINISH = 16'h0040;
  localparam logic [15:0] OFF_W      = 16'h0044;
  localparam logic [15:0] OFF_K      = 16'h0048;

  localparam int FIN_DONE  = 0;
  localparam int FIN_BUSY  = 1;
  localparam int FIN_CHAIN = 8;
  localparam int FIN_IRQEN = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int n = 0; n < 4; n++)
      if (be[n]) r[8*n +: 8] = new_v[8*n +: 8];
    return r;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// Combinational SHA-256 compression round terms T1 and T2.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] e_i,
  input  logic [31:0] f_i,
  input  logic [31:0] g_i,
  input  logic [31:0] h_i,
  input  logic [31:0] w_i,
  input  logic [31:0] k_i,
  output logic [31:0] t1_o,
  output logic [31:0] t2_o
);

  assign t1_o = h_i + big_sigma1(e_i) + ch(e_i, f_i, g_i) + k_i + w_i;
  assign t2_o = big_sigma0(a_i) + maj(a_i, b_i, c_i);

endmodule

// File: rtl/sha256_regs.sv
// Register window around one SHA-256 round: inputs A..H, W, K, results, control.
// Writing K while idle launches a two-edge round (CALC registers T1/T2, UPDATE loads outputs).
module sha256_regs
  import sha256_pkg::*;
#(
  parameter logic [15:0] P_BASE      = 16'h4000,
  parameter logic        P_CHAIN_DEF = 1'b0
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [15:0] WRADDR,
  input  logic [3:0]  BYTEEN,
  input  logic        WREN,
  input  logic [31:0] WDATA,
  input  logic [15:0] RDADDR,
  input  logic        RDEN,
  output logic [31:0] RDATA,
  output logic        SHA_IRQ
);

  state_e      state_q;
  logic [31:0] i_q [8];
  logic [31:0] o_q [8];
  logic [31:0] o_d [8];
  logic [31:0] w_q, k_q, t1_q, t2_q, t1_d, t2_d, rdata_q, rdata_d;
  logic        done_q, irqen_q, chain_q, busy;
  logic [15:0] wr_off, rd_off;
  logic        wr_i, wr_w, wr_k, wr_fin;

  assign busy   = (state_q != ST_IDLE);
  assign wr_off = WRADDR - P_BASE;
  assign rd_off = RDADDR - P_BASE;

  // Offsets are full 16-bit values, so anything outside the window or misaligned misses.
  assign wr_i   = WREN && !busy && (wr_off < OFF_OA) && (wr_off[1:0] == 2'b00);
  assign wr_w   = WREN && !busy && (wr_off == OFF_W);
  assign wr_k   = WREN && !busy && (wr_off == OFF_K);
  assign wr_fin = WREN && (wr_off == OFF_FINISH);

  sha256_round u_round (
    .a_i (i_q[0]), .b_i (i_q[1]), .c_i (i_q[2]),
    .e_i (i_q[4]), .f_i (i_q[5]), .g_i (i_q[6]), .h_i (i_q[7]),
    .w_i (w_q),    .k_i (k_q),
    .t1_o(t1_d),   .t2_o(t2_d)
  );

  always_comb begin
    o_d[0] = t1_q + t2_q;
    o_d[1] = i_q[0];
    o_d[2] = i_q[1];
    o_d[3] = i_q[2];
    o_d[4] = i_q[3] + t1_q;
    o_d[5] = i_q[4];
    o_d[6] = i_q[5];
    o_d[7] = i_q[6];
  end

  always_comb begin
    rdata_d = '0;
    if (rd_off[1:0] == 2'b00) begin
      if (rd_off < OFF_OA)            rdata_d = i_q[rd_off[4:2]];
      else if (rd_off < OFF_FINISH)   rdata_d = o_q[rd_off[4:2]];
      else if (rd_off == OFF_FINISH) begin
        rdata_d[FIN_DONE]  = done_q;
        rdata_d[FIN_BUSY]  = busy;
        rdata_d[FIN_CHAIN] = chain_q;
        rdata_d[FIN_IRQEN] = irqen_q;
      end
      else if (rd_off == OFF_W)       rdata_d = w_q;
      else if (rd_off == OFF_K)       rdata_d = k_q;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
      for (int j = 0; j < 8; j++) begin
        i_q[j] <= '0;
        o_q[j] <= '0;
      end
      w_q     <= '0;
      k_q     <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      done_q  <= 1'b0;
      irqen_q <= 1'b0;
      chain_q <= P_CHAIN_DEF;
      rdata_q <= '0;
    end else begin
      if (wr_i) i_q[wr_off[4:2]] <= be_merge(i_q[wr_off[4:2]], WDATA, BYTEEN);
      if (wr_w) w_q <= be_merge(w_q, WDATA, BYTEEN);
      if (wr_fin) begin
        if (BYTEEN[1]) chain_q <= WDATA[FIN_CHAIN];
        if (BYTEEN[2]) irqen_q <= WDATA[FIN_IRQEN];
        if (BYTEEN[0] && WDATA[FIN_DONE]) done_q <= 1'b0;
      end
      if (RDEN) rdata_q <= rdata_d;
      // FSM last so the UPDATE edge's DONE set overrides a same-edge clear.
      case (state_q)
        ST_IDLE: if (wr_k) begin
          k_q     <= be_merge(k_q, WDATA, BYTEEN);
          done_q  <= 1'b0;
          state_q <= ST_CALC;
        end
        ST_CALC: begin
          t1_q    <= t1_d;
          t2_q    <= t2_d;
          state_q <= ST_UPDATE;
        end
        ST_UPDATE: begin
          for (int j = 0; j < 8; j++) begin
            o_q[j] <= o_d[j];
            if (chain_q) i_q[j] <= o_d[j];
          end
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign RDATA   = rdata_q;
  assign SHA_IRQ = done_q & irqen_q;

endmodule

// File: tb/tb_sha256_regs.sv
// Directed bench for sha256_regs: register-map table plus hand-written round sequences.
module tb_sha256_regs;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [15:0] WRADDR;
  logic [3:0]  BYTEEN;
  logic        WREN;
  logic [31:0] WDATA;
  logic [15:0] RDADDR;
  logic        RDEN;
  logic [31:0] RDATA;
  logic        SHA_IRQ;

  int checks = 0;
  int errors = 0;

  sha256_regs dut (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .WRADDR (WRADDR),
    .BYTEEN (BYTEEN),
    .WREN   (WREN),
    .WDATA  (WDATA),
    .RDADDR (RDADDR),
    .RDEN   (RDEN),
    .RDATA  (RDATA),
    .SHA_IRQ(SHA_IRQ)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [15:0] wa;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [15:0] ra;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl [9];

  localparam logic [15:0] A_IA  = 16'h4000;
  localparam logic [15:0] A_OA  = 16'h4020;
  localparam logic [15:0] A_FIN = 16'h4040;
  localparam logic [15:0] A_W   = 16'h4044;
  localparam logic [15:0] A_K   = 16'h4048;

  logic [31:0] iv   [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  logic [31:0] oexp [8] = '{32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
                            32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
    WRADDR = a; BYTEEN = be; WDATA = d; WREN = 1'b1;
    @(posedge ACLK); #1;
    WREN = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    RDADDR = a; RDEN = 1'b1;
    @(posedge ACLK); #1;
    RDEN = 1'b0;
    d = RDATA;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge ACLK); #1;
    end
  endtask

  task automatic load_iv();
    for (int j = 0; j < 8; j++) wr(A_IA + 16'(4 * j), 4'hF, iv[j]);
    wr(A_W, 4'hF, 32'h61626380);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;

    tbl[0] = '{16'h4000, 4'b0001, 32'hFFFFFFFF, A_IA,     32'h000000FF, "iA_byteen0"};
    tbl[1] = '{16'h4004, 4'b1010, 32'h11223344, 16'h4004, 32'h11003300, "iB_byteen"};
    tbl[2] = '{16'h4020, 4'b1111, 32'hDEADBEEF, A_OA,     32'h00000000, "oA_readonly"};
    tbl[3] = '{16'h404C, 4'b1111, 32'hDEADBEEF, 16'h404C, 32'h00000000, "unmapped"};
    tbl[4] = '{16'hC000, 4'b1111, 32'hDEADBEEF, A_IA,     32'h000000FF, "alias_decode"};
    tbl[5] = '{16'h4044, 4'b1100, 32'hAABBCCDD, A_W,      32'hAABB0000, "W_byteen"};
    tbl[6] = '{16'h4040, 4'b0110, 32'h00010101, A_FIN,    32'h00010100, "finish_ctl_set"};
    tbl[7] = '{16'h4040, 4'b0110, 32'h00000000, A_FIN,    32'h00000000, "finish_ctl_clr"};
    tbl[8] = '{16'h4001, 4'b1111, 32'h12345678, A_IA,     32'h000000FF, "misaligned"};

    ARESETN = 1'b0; WRADDR = '0; BYTEEN = '0; WREN = 1'b0; WDATA = '0;
    RDADDR = '0; RDEN = 1'b0;
    #23 ARESETN = 1'b1;
    idle(1);

    check("reset_rdata", RDATA, 32'h0);
    check("reset_irq", {31'b0, SHA_IRQ}, 32'h0);
    rd(A_FIN, r); check("reset_finish", r, 32'h0);
    rd(A_IA, r);  check("reset_iA", r, 32'h0);

    for (int v = 0; v < 9; v++) begin
      wr(tbl[v].wa, tbl[v].be, tbl[v].wd);
      rd(tbl[v].ra, r);
      check(tbl[v].name, r, tbl[v].exp);
    end

    // Reference round, observing BUSY and the pre-update read on the UPDATE edge.
    load_iv();
    wr(A_K, 4'hF, 32'h428a2f98);
    rd(A_FIN, r); check("busy_in_calc", r, 32'h00000002);
    rd(A_OA, r);  check("oA_pre_update", r, 32'h0);
    for (int j = 0; j < 8; j++) begin
      rd(A_OA + 16'(4 * j), r);
      check($sformatf("round_o%0d", j), r, oexp[j]);
    end
    rd(A_FIN, r); check("done_set", r, 32'h00000001);
    RDADDR = A_OA; idle(1);
    check("rdata_hold", RDATA, 32'h00000001);
    rd(A_K, r); check("K_readback", r, 32'h428a2f98);

    // DONE clear on the UPDATE edge loses; a later clear wins.
    wr(A_K, 4'hF, 32'h428a2f98);
    idle(1);
    wr(A_FIN, 4'b0001, 32'h00000001);
    rd(A_FIN, r); check("w1c_update_loses", r, 32'h00000001);
    wr(A_FIN, 4'b0001, 32'h00000001);
    rd(A_FIN, r); check("w1c_clears", r, 32'h00000000);

    // Writes while busy are dropped.
    wr(A_K, 4'hF, 32'h428a2f98);
    wr(A_K, 4'hF, 32'h00000000);
    wr(A_IA, 4'hF, 32'h12345678);
    rd(A_FIN, r);       check("busy_write_done", r, 32'h00000001);
    rd(A_K, r);         check("busy_write_K", r, 32'h428a2f98);
    rd(A_IA, r);        check("busy_write_iA", r, 32'h6a09e667);
    rd(A_OA + 16, r);   check("busy_write_oE", r, 32'hfa2a4622);

    // CHAIN copies the results back into the inputs.
    wr(A_FIN, 4'b0010, 32'h00000100);
    wr(A_K, 4'hF, 32'h428a2f98);
    idle(2);
    rd(A_IA, r);      check("chain_iA", r, 32'h5d6aebcd);
    rd(A_IA + 16, r); check("chain_iE", r, 32'hfa2a4622);
    rd(A_FIN, r);     check("chain_finish", r, 32'h00000101);
    wr(A_FIN, 4'b0011, 32'h00000001);
    rd(A_FIN, r);     check("chain_off", r, 32'h00000000);

    // Interrupt level, then reset in the middle of a round.
    wr(A_FIN, 4'b0100, 32'h00010000);
    wr(A_K, 4'hF, 32'h428a2f98);
    check("irq_while_busy", {31'b0, SHA_IRQ}, 32'h0);
    idle(2);
    check("irq_set", {31'b0, SHA_IRQ}, 32'h1);
    wr(A_FIN, 4'b0001, 32'h00000001);
    check("irq_cleared", {31'b0, SHA_IRQ}, 32'h0);
    wr(A_K, 4'hF, 32'h428a2f98);
    #1 ARESETN = 1'b0;
    #1 check("reset_async_rdata", RDATA, 32'h0);
    #1 ARESETN = 1'b1;
    idle(1);
    rd(A_FIN, r); check("abort_finish", r, 32'h00000000);
    idle(2);
    rd(A_FIN, r); check("abort_no_done", r, 32'h00000000);
    rd(A_OA, r);  check("abort_oA", r, 32'h0);
    rd(A_IA, r);  check("abort_iA", r, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
